goodness_engine: RTL and testbench

GOODNESS_ENGINE -- requirements
Module: goodness_engine

---
 rtl/goodness_engine_if.sv | 26 ++
 rtl/goodness_engine.sv | 157 +++++++++++++++
 tb/tb_goodness_engine.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/goodness_engine_if.sv
// Activation stream in, scored result out, both valid/ready handshaked.
// The engine takes the slave modport; its producer/consumer takes the master modport.
interface goodness_engine_if #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32
);
    logic                         act_valid;
    logic                         act_ready;
    logic signed [DATA_WIDTH-1:0] act_data [LANES];
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] goodness_out;
    logic signed [DATA_WIDTH-1:0] margin_out;
    logic                         above_thresh;
    logic                         sat_flag;

    modport master (
        output act_valid, act_data, out_ready,
        input  act_ready, out_valid, goodness_out, margin_out, above_thresh, sat_flag
    );

    modport slave (
        input  act_valid, act_data, out_ready,
        output act_ready, out_valid, goodness_out, margin_out, above_thresh, sat_flag
    );
endinterface

// File: rtl/goodness_engine.sv
// Sum of squared fixed-point activations over one layer vector, compared against a threshold.
// Latency: out_valid rises 2 cycles after the last beat is accepted.
// Backpressure: act_ready only in ACCUM; the result is held with out_valid until out_ready.
module goodness_engine #(
    parameter int NUM_NEURONS = 256,
    parameter int LANES       = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 16,
    parameter int ACC_WIDTH   = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic signed [DATA_WIDTH-1:0] threshold,
    output logic                         busy,
    goodness_engine_if.slave             bus
);
    localparam int NUM_BEATS = NUM_NEURONS / LANES;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    localparam logic signed [ACC_WIDTH-1:0] ACC_POS_MAX =
        ACC_WIDTH'({1'b0, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH-1:0] ACC_NEG_MIN = ~ACC_POS_MAX;

    localparam logic [DATA_WIDTH-1:0] DW_POS_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] DW_NEG_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    if (NUM_NEURONS % LANES != 0) begin : g_chk_lanes
        $error("goodness_engine: NUM_NEURONS must be divisible by LANES");
    end
    if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_chk_acc
        $error("goodness_engine: ACC_WIDTH must be at least 2*DATA_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCUM    = 2'd1,
        S_SATURATE = 2'd2,
        S_OUTPUT   = 2'd3
    } state_t;

    state_t state_q, state_nxt;

    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic [CNT_W-1:0]               cnt_q;
    logic signed [DATA_WIDTH-1:0]   thr_q;
    logic signed [DATA_WIDTH-1:0]   goodness_q;
    logic signed [DATA_WIDTH-1:0]   margin_q;
    logic                           above_q;
    logic                           sat_q;

    logic signed [2*DATA_WIDTH-1:0] sq [LANES];
    logic signed [ACC_WIDTH-1:0]    beat_sum;
    logic signed [DATA_WIDTH-1:0]   g_sat;
    logic                           g_clip;
    logic signed [DATA_WIDTH:0]     diff;
    logic signed [DATA_WIDTH-1:0]   m_sat;
    logic                           m_clip;

    // Each product is formed at 2*DATA_WIDTH so nothing is lost before the shift.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sq[i]    = (bus.act_data[i] * bus.act_data[i]) >>> FRAC_BITS;
            beat_sum = beat_sum + ACC_WIDTH'(sq[i]);
        end
    end

    always_comb begin
        g_clip = 1'b0;
        g_sat  = acc_q[DATA_WIDTH-1:0];
        if (acc_q > ACC_POS_MAX) begin
            g_sat  = DW_POS_MAX;
            g_clip = 1'b1;
        end else if (acc_q < ACC_NEG_MIN) begin
            g_sat  = DW_NEG_MIN;
            g_clip = 1'b1;
        end
        // One extra bit holds any difference of two DATA_WIDTH values exactly.
        diff   = {g_sat[DATA_WIDTH-1], g_sat} - {thr_q[DATA_WIDTH-1], thr_q};
        m_clip = diff[DATA_WIDTH] != diff[DATA_WIDTH-1];
        m_sat  = diff[DATA_WIDTH-1:0];
        if (m_clip) begin
            m_sat = diff[DATA_WIDTH] ? DW_NEG_MIN : DW_POS_MAX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:     if (start) state_nxt = S_ACCUM;
                S_ACCUM:    if (bus.act_valid && cnt_q == LAST_BEAT) state_nxt = S_SATURATE;
                S_SATURATE: state_nxt = S_OUTPUT;
                S_OUTPUT:   if (bus.out_ready) state_nxt = S_IDLE;
                default:    state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            thr_q      <= '0;
            goodness_q <= '0;
            margin_q   <= '0;
            above_q    <= 1'b0;
            sat_q      <= 1'b0;
        end else if (abort) begin
            cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                        thr_q <= threshold;
                    end
                end
                S_ACCUM: begin
                    if (bus.act_valid) begin
                        acc_q <= acc_q + beat_sum;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_SATURATE: begin
                    goodness_q <= g_sat;
                    margin_q   <= m_sat;
                    above_q    <= g_sat > thr_q;
                    sat_q      <= g_clip | m_clip;
                end
                default: ;
            endcase
        end
    end

    assign busy             = (state_q != S_IDLE);
    assign bus.act_ready    = (state_q == S_ACCUM);
    assign bus.out_valid    = (state_q == S_OUTPUT);
    assign bus.goodness_out = goodness_q;
    assign bus.margin_out   = margin_q;
    assign bus.above_thresh = above_q;
    assign bus.sat_flag     = sat_q;
endmodule

// File: tb/tb_goodness_engine.sv
// Randomised and directed vectors scored against an arithmetic model through a result queue.
module tb_goodness_engine;
    localparam int NN = 8, LN = 4, DW = 32, FB = 16, AW = 64;
    localparam int BEATS = NN / LN;
    localparam longint MAXI = 64'sd2147483647;
    localparam longint MINI = -64'sd2147483648;

    typedef logic [31:0] vec_t [NN];
    typedef struct {
        logic [31:0] g;
        logic [31:0] m;
        logic        above;
        logic        sat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic signed [DW-1:0] threshold = '0;
    logic                 busy;

    goodness_engine_if #(.LANES(LN), .DATA_WIDTH(DW)) bus ();

    goodness_engine #(
        .NUM_NEURONS(NN), .LANES(LN), .DATA_WIDTH(DW), .FRAC_BITS(FB), .ACC_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .threshold (threshold),
        .busy      (busy),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t last_exp;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Real-valued rule: goodness = sum of squares in Q16.16, clipped; margin = clip(goodness - theta).
    function automatic exp_t model(input vec_t v, input logic [31:0] thr);
        longint sum, a, g, m, mc, t;
        exp_t   e;
        sum = 0;
        for (int i = 0; i < NN; i++) begin
            a   = longint'($signed(v[i]));
            sum = sum + ((a * a) >>> FB);
        end
        g  = (sum > MAXI) ? MAXI : (sum < MINI) ? MINI : sum;
        t  = longint'($signed(thr));
        m  = g - t;
        mc = (m > MAXI) ? MAXI : (m < MINI) ? MINI : m;
        e.g     = g[31:0];
        e.m     = mc[31:0];
        e.above = (g > t);
        e.sat   = (g != sum) || (mc != m);
        return e;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        case ($urandom_range(0, 3))
            0:       w = $urandom;
            1, 2:    begin
                w = $urandom_range(0, 32'h0003_FFFF);
                if ($urandom_range(0, 1) == 1) w = -w;
            end
            default: w = '0;
        endcase
        return w;
    endfunction

    // Monitor: every result handshake consumes one expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_result: got goodness 0x%08h with no vector pending",
                             bus.goodness_out);
                end else begin
                    e = exp_q.pop_front();
                    check32("goodness_out", bus.goodness_out, e.g);
                    check32("margin_out", bus.margin_out, e.m);
                    check1("above_thresh", bus.above_thresh, e.above);
                    check1("sat_flag", bus.sat_flag, e.sat);
                end
            end
        end
    end

    task automatic drive_beat(input vec_t v, input int b);
        for (int l = 0; l < LN; l++) bus.act_data[l] = v[b*LN + l];
    endtask

    task automatic send_vector(input vec_t v, input logic [31:0] thr, input bit stall,
                               input int hold, input bit pulse_start);
        exp_t e;
        int   b, guard;
        e = model(v, thr);
        exp_q.push_back(e);
        b = 0;
        guard = 0;
        @(posedge clk); #1;
        start = 1'b1;
        threshold = thr;
        bus.out_ready = (hold == 0);
        while (b < BEATS && guard < 100) begin
            @(posedge clk); #1;
            start = pulse_start;
            bus.act_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            drive_beat(v, b);
            @(negedge clk);
            if (bus.act_valid && bus.act_ready) b++;
            guard++;
        end
        if (b < BEATS) begin
            n_checks++;
            $display("FAIL beat_timeout: accepted %0d beats required %0d", b, BEATS);
        end
        @(posedge clk); #1;
        bus.act_valid = 1'b0;
        @(negedge clk);
        check1("latency_cycle1_out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        check1("latency_cycle2_out_valid", bus.out_valid, 1'b1);
        for (int k = 0; k < hold; k++) begin
            check1("hold_out_valid", bus.out_valid, 1'b1);
            check32("hold_goodness", bus.goodness_out, e.g);
            check32("hold_margin", bus.margin_out, e.m);
            @(posedge clk); #1;
            if (k == hold - 1) bus.out_ready = 1'b1;
            @(negedge clk);
        end
        guard = 0;
        while (!(bus.out_valid && bus.out_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check1("idle_after_handshake_busy", busy, 1'b0);
        check1("idle_after_handshake_out_valid", bus.out_valid, 1'b0);
        check32("result_held_goodness", bus.goodness_out, e.g);
        last_exp = e;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [31:0] thr;
        bus.act_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int l = 0; l < LN; l++) bus.act_data[l] = '0;
        last_exp = '{g: 32'h0, m: 32'h0, above: 1'b0, sat: 1'b0};

        #12;
        check32("reset_goodness", bus.goodness_out, 32'h0);
        check32("reset_margin", bus.margin_out, 32'h0);
        check1("reset_above", bus.above_thresh, 1'b0);
        check1("reset_sat", bus.sat_flag, 1'b0);
        check1("reset_out_valid", bus.out_valid, 1'b0);
        check1("reset_busy", busy, 1'b0);
        check1("reset_act_ready", bus.act_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < NN; i++) v[i] = 32'h0001_0000;
        send_vector(v, 32'h0004_0000, 1'b0, 0, 1'b0);

        for (int i = 0; i < NN; i++) v[i] = (i % 2 == 0) ? 32'hFFFF_0000 : 32'h0001_0000;
        send_vector(v, 32'h0008_0000, 1'b0, 0, 1'b0);

        for (int i = 0; i < NN; i++) v[i] = 32'h7FFF_FFFF;
        send_vector(v, 32'h8000_0000, 1'b0, 0, 1'b0);

        for (int i = 0; i < NN; i++) v[i] = rand_word();
        thr = $urandom_range(0, 32'h0010_0000);
        send_vector(v, thr, 1'b0, 0, 1'b0);
        send_vector(v, thr, 1'b1, 5, 1'b0);

        // start held through ACCUM, OUTPUT and the result handshake itself
        send_vector(v, thr, 1'b1, 3, 1'b1);

        // abort on the cycle of the second beat handshake
        for (int i = 0; i < NN; i++) v[i] = 32'h0010_0000;
        @(posedge clk); #1;
        start = 1'b1;
        threshold = 32'h0000_1000;
        @(posedge clk); #1;
        start = 1'b0;
        bus.act_valid = 1'b1;
        drive_beat(v, 0);
        @(posedge clk); #1;
        drive_beat(v, 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        bus.act_valid = 1'b0;
        @(negedge clk);
        check1("abort_busy", busy, 1'b0);
        check1("abort_act_ready", bus.act_ready, 1'b0);
        check32("abort_results_kept", bus.goodness_out, last_exp.g);
        repeat (3) @(negedge clk);
        check1("abort_no_out_valid", bus.out_valid, 1'b0);
        for (int i = 0; i < NN; i++) v[i] = '0;
        send_vector(v, 32'h0000_0100, 1'b0, 0, 1'b0);

        for (int n = 0; n < 16; n++) begin
            for (int i = 0; i < NN; i++) v[i] = rand_word();
            thr = ($urandom_range(0, 1) == 1) ? $urandom : $urandom_range(0, 32'h0020_0000);
            send_vector(v, thr, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end

        // asynchronous reset in the middle of a vector
        for (int i = 0; i < NN; i++) v[i] = 32'h0003_0000;
        @(posedge clk); #1;
        start = 1'b1;
        threshold = 32'h0000_0010;
        @(posedge clk); #1;
        start = 1'b0;
        bus.act_valid = 1'b1;
        drive_beat(v, 0);
        @(posedge clk); #1;
        bus.act_valid = 1'b0;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check32("midreset_goodness", bus.goodness_out, 32'h0);
        check32("midreset_margin", bus.margin_out, 32'h0);
        check1("midreset_above", bus.above_thresh, 1'b0);
        check1("midreset_sat", bus.sat_flag, 1'b0);
        check1("midreset_busy", busy, 1'b0);
        check1("midreset_act_ready", bus.act_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.act_valid = 1'b1;
        drive_beat(v, 1);
        repeat (4) @(negedge clk);
        check1("postreset_no_out_valid", bus.out_valid, 1'b0);
        check1("postreset_busy", busy, 1'b0);
        bus.act_valid = 1'b0;

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL pending_results: got %0d unconsumed expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
